// File: rtl/mpf_vtp_port_arb_if.sv
// mpf_vtp_port_arb_if: requester-side and service-side handshakes of the VTP port arbiter.
interface mpf_vtp_port_arb_if #(parameter int N_PORTS = 2, REQ_W = 64, RSP_W = 64);
  logic [N_PORTS-1:0] req_valid, req_ready, rsp_valid;
  logic [N_PORTS*REQ_W-1:0] req_data;
  logic [N_PORTS*RSP_W-1:0] rsp_data;
  logic svc_req_valid, svc_req_ready, svc_rsp_valid;
  logic [REQ_W-1:0] svc_req_data;
  logic [RSP_W-1:0] svc_rsp_data;
  modport master(
    input req_valid, req_data, svc_req_ready, svc_rsp_valid, svc_rsp_data,
    output req_ready, rsp_valid, rsp_data, svc_req_valid, svc_req_data
  );
  modport slave(
    output req_valid, req_data, svc_req_ready, svc_rsp_valid, svc_rsp_data,
    input req_ready, rsp_valid, rsp_data, svc_req_valid, svc_req_data
  );
endinterface

// File: rtl/mpf_vtp_port_arb.sv
// mpf_vtp_port_arb: round-robin sharing of one in-order VTP translation service among N_PORTS requesters.
module mpf_vtp_port_arb #(
  parameter int N_PORTS = 2,
  parameter int REQ_W = 64,
  parameter int RSP_W = 64,
  parameter int MAX_OUTSTANDING = 8
)(
  input  logic clk,
  input  logic reset,
  mpf_vtp_port_arb_if.master bus,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic err_unexpected_rsp
);
  localparam int PW = N_PORTS > 1 ? $clog2(N_PORTS) : 1;
  localparam int AW = $clog2(MAX_OUTSTANDING);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(MAX_OUTSTANDING);
  logic [PW-1:0] ptr_q, ptr_d, gnt_idx, head;
  logic [PW-1:0] tag_q [MAX_OUTSTANDING];
  logic [PW-1:0] tag_d [MAX_OUTSTANDING];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic svc_valid_q, svc_valid_d, err_q, err_d, grant, pop;
  logic [REQ_W-1:0] svc_data_q, svc_data_d;
  logic [N_PORTS-1:0] rsp_valid_q, rsp_valid_d, ready;
  logic [N_PORTS*RSP_W-1:0] rsp_data_q, rsp_data_d;
  // Limit uses the registered count so svc_rsp_valid never reaches req_ready combinationally.
  always_comb begin
    grant = 1'b0;
    gnt_idx = '0;
    ready = '0;
    if ((!svc_valid_q || bus.svc_req_ready) && cnt_q != FULL)
      for (int k = N_PORTS - 1; k >= 0; k--)
        if (bus.req_valid[(int'(ptr_q) + k) % N_PORTS]) begin
          grant = 1'b1;
          gnt_idx = PW'((int'(ptr_q) + k) % N_PORTS);
        end
    ready[gnt_idx] = grant;
  end
  assign pop = bus.svc_rsp_valid && cnt_q != '0;
  assign head = tag_q[rd_q];
  always_comb begin
    ptr_d = grant ? (int'(gnt_idx) == N_PORTS - 1 ? '0 : gnt_idx + PW'(1)) : ptr_q;
    svc_valid_d = grant || (svc_valid_q && !bus.svc_req_ready);
    svc_data_d = grant ? bus.req_data[int'(gnt_idx)*REQ_W +: REQ_W] : svc_data_q;
    tag_d = tag_q;
    if (grant) tag_d[wr_q] = gnt_idx;
    wr_d = grant ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + CW'(grant) - CW'(pop);
    err_d = err_q || (bus.svc_rsp_valid && !pop);
    rsp_valid_d = '0;
    rsp_data_d = rsp_data_q;
    if (pop) begin
      rsp_valid_d[head] = 1'b1;
      rsp_data_d[int'(head)*RSP_W +: RSP_W] = bus.svc_rsp_data;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      tag_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      svc_valid_q <= 1'b0;
      svc_data_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      tag_q <= tag_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      svc_valid_q <= svc_valid_d;
      svc_data_q <= svc_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
      err_q <= err_d;
    end
  end
  assign bus.req_ready = ready;
  assign bus.svc_req_valid = svc_valid_q;
  assign bus.svc_req_data = svc_data_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data = rsp_data_q;
  assign outstanding = cnt_q;
  assign err_unexpected_rsp = err_q;
endmodule

// File: doc/mpf_vtp_port_arb.md
Name: mpf_vtp_port_arb

Overview:
- Shares one VTP translation service port between N_PORTS requesters, for example the c0 read and c1 write translation paths of a CCI-P VTP shim.
- Arbitrates lookup requests round-robin and forwards them to the single service port.
- Records which requester owns each outstanding lookup, then routes the in-order service responses back to that requester.
- Sits between the per-channel translate pipelines and the shared VTP TLB/page-walk service.

Parameters:
- N_PORTS, 2, number of requesters (2..8).
- REQ_W, 64, request payload width (address plus flags).
- RSP_W, 64, response payload width (physical address, error, isSpeculative).
- MAX_OUTSTANDING, 8, tag FIFO depth; power of 2, at least 2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  N_PORTS  per-port lookup request valid.
- req_data  in  N_PORTS*REQ_W  per-port request payload; port i occupies bits [i*REQ_W +: REQ_W].
- req_ready  out  N_PORTS  per-port grant; the request is accepted when valid and ready are both high.
- rsp_valid  out  N_PORTS  per-port response valid, one-cycle pulse, no backpressure.
- rsp_data  out  N_PORTS*RSP_W  per-port response payload.
- svc_req_valid  out  1  request valid to the shared service.
- svc_req_data  out  REQ_W  request payload to the service.
- svc_req_ready  in  1  service accepts the request.
- svc_rsp_valid  in  1  service response valid; responses return in request order.
- svc_rsp_data  in  RSP_W  service response payload.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  live count of lookups granted but not yet answered.
- err_unexpected_rsp  out  1  sticky flag: a response arrived while nothing was outstanding.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - svc_req_valid=0, svc_req_data=0, rsp_valid=0, rsp_data=0.
  - outstanding=0, err_unexpected_rsp=0.
  - Tag FIFO empty; round-robin pointer=0.
  - Reset mid-operation discards all in-flight lookups. Responses still arriving after reset release are unexpected and set err_unexpected_rsp.
- Output stage: a single register (svc_req_valid/svc_req_data). It is free when svc_req_valid=0 or svc_req_ready=1 in the current cycle.
- Grant rule (combinational, same cycle):
  - can_grant = output stage free AND outstanding < MAX_OUTSTANDING.
  - If can_grant, exactly one req_ready bit is raised: the first valid port at or after the pointer, scanning upward with wrap.
  - req_ready never asserts for a port whose req_valid=0. All req_ready bits are 0 when can_grant=0.
- On grant of port g:
  - Next cycle svc_req_valid=1 and svc_req_data=req_data[g].
  - Push g into the tag FIFO.
  - Pointer becomes (g+1) mod N_PORTS.
  - With no grant, the pointer holds.
- Output stage with no grant: if svc_req_ready=1 and no new grant occurs, svc_req_valid clears next cycle. Data holds stable while valid=1 and ready=0.
- Request-to-service latency: 1 cycle from acceptance to svc_req_valid.
- Response routing (registered):
  - On svc_rsp_valid with the FIFO non-empty, pop head h.
  - Next cycle rsp_valid[h]=1 and rsp_data[h]=svc_rsp_data. All other rsp_valid bits are 0.
  - rsp_data for non-selected ports holds its previous value.
  - Response latency: 1 cycle.
- svc_rsp_valid with the FIFO empty: response dropped, err_unexpected_rsp set. It stays set until reset.
- Counter: outstanding increments on grant and decrements on a valid pop.
  - A grant and a pop in the same cycle leave it unchanged.
  - When outstanding == MAX_OUTSTANDING, no grant is issued even if a pop occurs that cycle. The limit uses the registered count, which avoids a combinational path from svc_rsp_valid to req_ready.
- FIFO pointers wrap modulo MAX_OUTSTANDING. Simultaneous push and pop are legal at any occupancy below full.
- Fairness: a port with req_valid held high is granted within N_PORTS grant opportunities.
- Single requester: it may be granted every cycle while svc_req_ready=1 and the outstanding limit is not reached.

Test Plan:
- Reset, then port0 request data 0x1000 with svc_req_ready=1 -> req_ready[0]=1 in that cycle; next cycle svc_req_valid=1 and svc_req_data=0x1000; outstanding=1. Service response 0xABC0 -> one cycle later rsp_valid=2'b01 and rsp_data[0]=0xABC0; outstanding=0.
- Both ports hold valid continuously, svc_req_ready=1, service echoes each request in order -> grants alternate 0,1,0,1. Responses arrive on ports 0,1,0,1 with matching payloads.
- MAX_OUTSTANDING=8, port1 streams with no responses returned -> exactly 8 grants, then req_ready=0 and outstanding=8. One response -> grant resumes on the following cycle.
- svc_req_ready low for 5 cycles with svc_req_valid=1 -> svc_req_data stable, req_ready all 0. On ready high, next grant in the same cycle.
- svc_rsp_valid pulse with outstanding=0 -> no rsp_valid and err_unexpected_rsp=1 persisting. Assert reset -> err_unexpected_rsp=0 immediately, before the next clock edge.
- Reset asserted with 3 outstanding and svc_req_valid=1 -> all outputs 0 immediately, outstanding=0. Post-reset grants start at port 0.
